// File: rtl/csr_counter_unit.sv
// Cycle/instret counter block: 64-bit counters plus the registered MEM->WB read path that
// feeds CSR_cyc into the writeback select.
module csr_counter_unit #(
  parameter int unsigned CNT_W      = 64,
  parameter bit          INSTRET_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_rd_en_M,
  input  logic [11:0] csr_addr_M,
  input  logic        stall_W,
  input  logic        flush_W,
  input  logic        retire_W,
  output logic [31:0] CSR_cyc,
  output logic        csr_illegal_W
);

  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;
  logic [31:0]      r_csr_data;
  logic             r_csr_illegal;

  logic [31:0]      w_rd_data;
  logic             w_rd_illegal;
  logic             w_instret_inc;

  // A stalled WB instruction is counted once, on the edge it actually leaves.
  assign w_instret_inc = INSTRET_EN && retire_W && !stall_W;

  // Decode reads the pre-increment counters, so a read sees the count of its own MEM cycle.
  always_comb begin
    w_rd_data    = 32'h0;
    w_rd_illegal = 1'b0;
    case (csr_addr_M)
      12'hC00, 12'hB00: w_rd_data = r_cycle_cnt[31:0];
      12'hC80, 12'hB80: w_rd_data = r_cycle_cnt[63:32];
      12'hC02, 12'hB02: w_rd_data = r_instret_cnt[31:0];
      12'hC82, 12'hB82: w_rd_data = r_instret_cnt[63:32];
      default:          w_rd_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instret_cnt <= '0;
    end else if (w_instret_inc) begin
      r_instret_cnt <= r_instret_cnt + CNT_W'(1);
    end
  end

  // Stall outranks flush: a held W stage keeps its data even when a bubble is requested.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_csr_data    <= 32'h0;
      r_csr_illegal <= 1'b0;
    end else if (stall_W) begin
      r_csr_data    <= r_csr_data;
      r_csr_illegal <= r_csr_illegal;
    end else if (flush_W) begin
      r_csr_data    <= 32'h0;
      r_csr_illegal <= 1'b0;
    end else if (csr_rd_en_M) begin
      r_csr_data    <= w_rd_data;
      r_csr_illegal <= w_rd_illegal;
    end else begin
      r_csr_data    <= 32'h0;
      r_csr_illegal <= 1'b0;
    end
  end

  assign CSR_cyc       = r_csr_data;
  assign csr_illegal_W = r_csr_illegal;

endmodule

// File: tb/tb_csr_counter_unit.sv
// Scoreboard bench for csr_counter_unit: stimulus queues the expected W-stage word per edge,
// a monitor pops and compares after every rising edge.
module tb_csr_counter_unit;

  logic        clk;
  logic        rst_n;
  logic        csr_rd_en_M;
  logic [11:0] csr_addr_M;
  logic        stall_W;
  logic        flush_W;
  logic        retire_W;
  logic [31:0] CSR_cyc;
  logic        csr_illegal_W;

  int n_checks;
  int n_fail;

  logic [32:0] exp_q[$];
  string       name_q[$];
  logic [63:0] t_cyc;

  csr_counter_unit #(
    .CNT_W     (64),
    .INSTRET_EN(1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr_rd_en_M  (csr_rd_en_M),
    .csr_addr_M   (csr_addr_M),
    .stall_W      (stall_W),
    .flush_W      (flush_W),
    .retire_W     (retire_W),
    .CSR_cyc      (CSR_cyc),
    .csr_illegal_W(csr_illegal_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one queued expectation per edge.
  initial begin
    logic [32:0] e;
    string       nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (CSR_cyc !== e[31:0] || csr_illegal_W !== e[32]) begin
          n_fail++;
          $display("FAIL %s: got data=%h illegal=%b, want data=%h illegal=%b",
                   nm, CSR_cyc, csr_illegal_W, e[31:0], e[32]);
        end
      end
    end
  end

  // Drive one cycle at the current negedge, queue the response of the next edge, advance.
  task automatic step(input logic rst, input logic rd, input logic [11:0] addr,
                      input logic stall, input logic flush, input logic retire,
                      input logic [31:0] exp_d, input logic exp_ill, input string nm);
    rst_n       = rst;
    csr_rd_en_M = rd;
    csr_addr_M  = addr;
    stall_W     = stall;
    flush_W     = flush;
    retire_W    = retire;
    exp_q.push_back({exp_ill, exp_d});
    name_q.push_back(nm);
    if (!rst) t_cyc = 64'h0;
    else      t_cyc = t_cyc + 64'h1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input string nm);
    step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, nm);
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic force_cyc(input logic [63:0] val);
    force dut.r_cycle_cnt = val;
    #1;
    release dut.r_cycle_cnt;
    t_cyc = val;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    t_cyc       = 64'h0;
    rst_n       = 1'b0;
    csr_rd_en_M = 1'b0;
    csr_addr_M  = 12'h0;
    stall_W     = 1'b0;
    flush_W     = 1'b0;
    retire_W    = 1'b0;
    @(negedge clk);

    step(1'b0, 1'b1, 12'hC00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, "reset_out0");
    step(1'b0, 1'b1, 12'hC03, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, "reset_out1");
    chk64("reset_cycle", dut.r_cycle_cnt, 64'h0);
    chk64("reset_instret", dut.r_instret_cnt, 64'h0);

    // Cycle read after 9 idle edges.
    for (int i = 0; i < 9; i++) idle("idle_pre_read");
    step(1'b1, 1'b1, 12'hC00, 1'b0, 1'b0, 1'b0, 32'd9, 1'b0, "cycle_read_9");
    idle("cycle_read_clear");

    // instret: 4 counted, 3 stalled, same-cycle retire excluded from the read.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, "retire");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 12'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, "retire_stalled");
    step(1'b1, 1'b1, 12'hC02, 1'b0, 1'b0, 1'b1, 32'd4, 1'b0, "instret_read_4");
    chk64("instret_after_read", dut.r_instret_cnt, 64'd5);
    step(1'b1, 1'b1, 12'hC82, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "instret_hi_0");

    // Stall/flush on the output register.
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, "retire_to_17");
    step(1'b1, 1'b1, 12'hB02, 1'b0, 1'b0, 1'b0, 32'h11, 1'b0, "instret_b02_11");
    step(1'b1, 1'b1, 12'hC00, 1'b1, 1'b1, 1'b0, 32'h11, 1'b0, "stall_flush_hold1");
    step(1'b1, 1'b1, 12'hC00, 1'b1, 1'b1, 1'b0, 32'h11, 1'b0, "stall_flush_hold2");
    step(1'b1, 1'b1, 12'hC00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, "flush_clear");
    chk64("cycle_runs_through_stall", dut.r_cycle_cnt, t_cyc);

    // Illegal address.
    step(1'b1, 1'b1, 12'hC03, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "illegal_c03");
    idle("illegal_clear");
    chk64("illegal_instret", dut.r_instret_cnt, 64'd17);
    chk64("illegal_cycle", dut.r_cycle_cnt, t_cyc);
    step(1'b1, 1'b1, 12'hB00, 1'b0, 1'b0, 1'b0, t_cyc[31:0], 1'b0, "cycle_b00");

    // High-half carry and 64-bit wrap.
    force_cyc(64'h0000_0000_FFFF_FFFF);
    step(1'b1, 1'b1, 12'hC80, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "carry_hi_before");
    step(1'b1, 1'b1, 12'hB80, 1'b0, 1'b0, 1'b0, 32'h1, 1'b0, "carry_hi_after");
    step(1'b1, 1'b1, 12'hC00, 1'b0, 1'b0, 1'b0, 32'h1, 1'b0, "carry_lo_after");
    chk64("carry_cycle", dut.r_cycle_cnt, 64'h0000_0001_0000_0002);
    force_cyc(64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, 1'b1, 12'hC00, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, "wrap_lo_before");
    chk64("wrap_cycle_zero", dut.r_cycle_cnt, 64'h0);
    step(1'b1, 1'b1, 12'hC00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "wrap_lo_zero");
    step(1'b1, 1'b1, 12'hC80, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "wrap_hi_zero");
    step(1'b1, 1'b1, 12'hB82, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "instret_b82_0");

    // Reset mid-run with a read in MEM.
    for (int i = 0; i < 50; i++) idle("idle_pre_reset");
    step(1'b0, 1'b1, 12'hC00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, "midrun_reset_out");
    chk64("midrun_reset_cycle", dut.r_cycle_cnt, 64'h0);
    chk64("midrun_reset_instret", dut.r_instret_cnt, 64'h0);
    idle("post_reset_1");
    idle("post_reset_2");
    step(1'b1, 1'b1, 12'hC00, 1'b0, 1'b0, 1'b0, 32'd2, 1'b0, "post_reset_read_2");
    idle("post_reset_clear");

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_counter_unit.md
Name: csr_counter_unit

Overview:
- Produces the `CSR_cyc` word consumed by the writeback data select when `WB_data_src_W` = 3'b111.
- Maintains the 64-bit cycle and instret counters.
- Decodes read-only counter CSR reads in the MEM stage and registers the selected 32-bit value into the MEM/WB boundary, so `CSR_cyc` arrives aligned with the other W-stage writeback sources.

Parameters:
- CNT_W, 64, counter width; fixed at 64 (upper/lower halves readable); any other value unsupported.
- INSTRET_EN, 1, 1 = instret counts retirements; 0 = instret held at 0.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- csr_rd_en_M  input  1  CSR counter read instruction valid in MEM stage
- csr_addr_M  input  12  CSR address of that instruction
- stall_W  input  1  MEM/WB register hold; 1 = keep W-stage outputs
- flush_W  input  1  bubble into W stage; 1 = W-stage outputs cleared next edge
- retire_W  input  1  valid, non-bubble instruction retiring in WB this cycle
- CSR_cyc  output  32  registered CSR read data for writeback select
- csr_illegal_W  output  1  registered flag: W-stage CSR read hit an unimplemented address

Behaviour:
- Reset (rst_n=0 at an edge):
  - cycle_cnt=0, instret_cnt=0, CSR_cyc=0, csr_illegal_W=0.
  - Reset mid-operation discards any pending read; no partial state survives.
- cycle_cnt:
  - +1 on every edge with rst_n=1, independent of stall/flush.
  - 64-bit wrap: 0xFFFF_FFFF_FFFF_FFFF -> 0.
  - Carry into the upper half lands in the same edge (no split-half update).
- instret_cnt:
  - +1 on every edge with rst_n=1, retire_W=1 and stall_W=0 (a stalled WB instruction counts once, when it leaves).
  - Same 64-bit wrap.
  - INSTRET_EN=0: stays 0.
- Address decode (combinational, MEM stage):
  - 0xC00/0xB00 -> cycle[31:0]
  - 0xC80/0xB80 -> cycle[63:32]
  - 0xC02/0xB02 -> instret[31:0]
  - 0xC82/0xB82 -> instret[63:32]
  - Any other address -> data 0, illegal=1.
- Snapshot rule: the value read is the counter value before this edge's increment, i.e. the count in the cycle the read sits in MEM.
  - A same-cycle retirement is not included.
- Output register update priority per edge:
  1. rst_n=0 -> clear.
  2. stall_W=1 -> hold CSR_cyc and csr_illegal_W (takes priority over flush_W).
  3. flush_W=1 -> CSR_cyc=0, illegal=0.
  4. csr_rd_en_M=1 -> CSR_cyc=decoded data, illegal=decode flag.
  5. Otherwise -> CSR_cyc=0, illegal=0.
- Latency: exactly one cycle from MEM-stage read to W-stage CSR_cyc.
- No internal stall generation.
- No CSR writes: write attempts are decoded upstream and never reach this block.
- Reading high then low half is not atomic. Software uses the standard hi/lo/hi retry loop; no shadow latch.

Test Plan:
- Cycle read:
  - Stimulus: release reset, leave csr_rd_en_M low for 9 edges, then csr_rd_en_M=1, addr=0xC00.
  - Required: CSR_cyc=9 one edge later, csr_illegal_W=0; the next idle cycle returns CSR_cyc=0.
- instret with stall and same-cycle retire:
  - Stimulus: retire_W=1 for 4 edges with stall_W=0, then retire_W=1 with stall_W=1 for 3 edges, then read 0xC02 in a cycle where retire_W=1, stall_W=0.
  - Required: CSR_cyc=4 (stalled cycles and the same-cycle retire excluded); instret_cnt becomes 5 after that edge.
- Wrap and high-half carry:
  - Stimulus: force cycle_cnt=0x0000_0000_FFFF_FFFF; read 0xC80 at that cycle, then 0xC80 again one cycle later.
  - Required: first read CSR_cyc=0x0000_0000, second read 0x0000_0001.
  - Also: from 0xFFFF_FFFF_FFFF_FFFF the counter becomes 0 and a 0xC00 read returns 0.
- Stall/flush on output:
  - Stimulus: read 0xB02 giving CSR_cyc=0x11, then stall_W=1 with flush_W=1 for 2 edges, then flush_W=1 alone.
  - Required: CSR_cyc holds 0x11 for both stalled edges, then clears to 0.
- Illegal address:
  - Stimulus: read 0xC03.
  - Required: CSR_cyc=0, csr_illegal_W=1 for one cycle; counters unaffected.
- Reset mid-run:
  - Stimulus: after 50 cycles with a read of 0xC00 in MEM, assert rst_n=0 for one edge.
  - Required: CSR_cyc=0, counters=0; first read after release at cycle-count 2 returns 2.
